// File: rtl/truth_table_sequencer_pkg.sv
// rtl/truth_table_sequencer_pkg.sv - shared state encoding and row-count helper for the truth table sequencer
package truth_table_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  function automatic int rows_of(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/truth_table_sequencer_settle_timer.sv
// rtl/truth_table_sequencer_settle_timer.sv - per-vector settle counter, expires on its last settle clock
module truth_table_sequencer_settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int W = (SETTLE_CYCLES + 1 > 2) ? $clog2(SETTLE_CYCLES + 1) : 1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == W'(SETTLE_CYCLES - 1));

endmodule

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - sweeps every input vector of a combinational function and checks it against a golden table
module truth_table_sequencer
  import truth_table_sequencer_pkg::*;
#(
  parameter int                    N_IN          = 4,
  parameter int                    SETTLE_CYCLES = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECTED      = 16'h6996
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   dut_f,
  output logic [N_IN-1:0]        dut_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   tt,
  output logic                   match,
  output logic [N_IN:0]          mismatch_cnt
);

  localparam int              ROWS     = rows_of(N_IN);
  localparam logic [N_IN-1:0] LAST_IDX = N_IN'(ROWS - 1);

  state_e            state_q, state_d;
  logic [N_IN-1:0]   idx_q, idx_d;
  logic [N_IN-1:0]   dut_in_q, dut_in_d;
  logic [ROWS-1:0]   tt_q, tt_d;
  logic [N_IN:0]     mis_q, mis_d;
  logic              match_q, match_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              timer_clear;
  logic              timer_en;
  logic              timer_expire;

  truth_table_sequencer_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (timer_expire)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dut_in_d    = dut_in_q;
    tt_d        = tt_q;
    mis_d       = mis_q;
    match_d     = match_q;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d       = '0;
          dut_in_d    = '0;
          tt_d        = '0;
          mis_d       = '0;
          match_d     = 1'b0;
          timer_clear = 1'b1;
          state_d     = S_SETTLE;
        end
      end
      S_SETTLE: begin
        timer_en = 1'b1;
        if (timer_expire) begin
          state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        tt_d[idx_q] = dut_f;
        if (dut_f != EXPECTED[idx_q]) begin
          mis_d = mis_q + 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          // match is resolved here so it is already valid in the cycle done is high
          match_d = (mis_d == '0);
          state_d = S_DONE;
        end else begin
          idx_d       = idx_q + 1'b1;
          dut_in_d    = idx_q + 1'b1;
          timer_clear = 1'b1;
          state_d     = S_SETTLE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      dut_in_q <= '0;
      tt_q     <= '0;
      mis_q    <= '0;
      match_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dut_in_q <= dut_in_d;
      tt_q     <= tt_d;
      mis_q    <= mis_d;
      match_q  <= match_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign dut_in       = dut_in_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tt           = tt_q;
  assign match        = match_q;
  assign mismatch_cnt = mis_q;

endmodule
